// File: rtl/dvp_capture_if.sv
// Camera-side inputs and pixel-side outputs of dvp_capture, grouped as one bundle.
// Stats ports exist only when DVP_CAPTURE_STATS_EN is defined.
interface dvp_capture_if;
   logic [7:0]  data_cam;
   logic        VSYNC_cam;
   logic        HREF_cam;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [15:0] pix_x;
   logic [15:0] line_y;
   logic        frame_start;
   logic        frame_end;
   logic        frame_err;
`ifdef DVP_CAPTURE_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;
`endif

   // Camera model / consumer side
   modport master (
      output data_cam, VSYNC_cam, HREF_cam,
      input  pix_data, pix_valid, pix_x, line_y, frame_start, frame_end, frame_err
`ifdef DVP_CAPTURE_STATS_EN
      , input frame_cnt, err_cnt
`endif
   );

   // Capture block side
   modport slave (
      input  data_cam, VSYNC_cam, HREF_cam,
      output pix_data, pix_valid, pix_x, line_y, frame_start, frame_end, frame_err
`ifdef DVP_CAPTURE_STATS_EN
      , output frame_cnt, err_cnt
`endif
   );
endinterface

// File: rtl/dvp_capture.sv
// DVP camera capture: registers the camera bus, assembles pixels and tracks frame geometry.
// Optional frame/error counters are enabled with DVP_CAPTURE_STATS_EN.
module dvp_capture #(
   parameter int COLOR_MODE = 2,
   parameter int H_PIX      = 640,
   parameter int V_LINES    = 480
) (
   input logic          PCLK_cam,
   input logic          rst,
   dvp_capture_if.slave bus
);

   localparam int unsigned W_CNT = 16;
   localparam logic [W_CNT-1:0] C_H_PIX   = W_CNT'(H_PIX);
   localparam logic [W_CNT-1:0] C_V_LINES = W_CNT'(V_LINES);
   localparam logic [W_CNT-1:0] C_MAX     = {W_CNT{1'b1}};
   localparam bit C_RGB = (COLOR_MODE == 2);

   typedef enum logic [1:0] {WAIT_VS, VS_HIGH, ACTIVE, LINE} state_t;

   function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
      return (v == C_MAX) ? v : v + W_CNT'(1);
   endfunction

   // input stage
   logic [7:0] r_data;
   logic       r_vs;
   logic       r_href;

   state_t r_state, w_state_nxt;
   logic   w_frame_begin;

   // line/frame tracking
   logic [7:0]       r_hi;
   logic             r_phase;
   logic [W_CNT-1:0] r_x;
   logic [W_CNT-1:0] r_y;
   logic             r_err_acc;
   logic             r_started;

   // assembled pixel, one stage ahead of the outputs
   logic             r_s2_vld;
   logic             r_s2_first;
   logic [15:0]      r_s2_word;
   logic [W_CNT-1:0] r_s2_x;
   logic [W_CNT-1:0] r_s2_y;

   logic [15:0]      r_pix_data;
   logic             r_pix_valid;
   logic [W_CNT-1:0] r_pix_x;
   logic [W_CNT-1:0] r_line_y;
   logic             r_frame_start;
   logic             r_frame_end;
   logic             r_frame_err;

   logic             w_in_frame;
   logic             w_cap;
   logic             w_phase;
   logic             w_pix;
   logic             w_close;
   logic             w_line_err;
   logic [W_CNT-1:0] w_y_nxt;
   logic             w_frame_end;
   logic             w_frame_err;
   logic [15:0]      w_pix_word;

   always_ff @(posedge PCLK_cam or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_vs   <= 1'b0;
         r_href <= 1'b0;
      end else begin
         r_data <= bus.data_cam;
         r_vs   <= bus.VSYNC_cam;
         r_href <= bus.HREF_cam;
      end
   end

   always_ff @(posedge PCLK_cam or posedge rst) begin
      if (rst) r_state <= WAIT_VS;
      else     r_state <= w_state_nxt;
   end

   // A frame only opens on a full VSYNC high-then-low, so a partial frame is never captured
   always_comb begin
      w_state_nxt   = r_state;
      w_frame_begin = 1'b0;
      case (r_state)
         WAIT_VS: if (r_vs) w_state_nxt = VS_HIGH;
         VS_HIGH: begin
            if (!r_vs) begin
               w_state_nxt   = ACTIVE;
               w_frame_begin = 1'b1;
            end
         end
         ACTIVE: begin
            if (r_vs)        w_state_nxt = VS_HIGH;
            else if (r_href) w_state_nxt = LINE;
         end
         LINE: begin
            if (r_vs)         w_state_nxt = VS_HIGH;
            else if (!r_href) w_state_nxt = ACTIVE;
         end
         default: w_state_nxt = WAIT_VS;
      endcase
   end

   // Byte qualification, line close and end-of-frame decisions
   always_comb begin
      w_in_frame  = (r_state == ACTIVE) || (r_state == LINE);
      w_cap       = w_in_frame && r_href && !r_vs;
      w_phase     = (r_state == LINE) ? r_phase : 1'b0;
      w_pix       = w_cap && (!C_RGB || w_phase);
      w_close     = (r_state == LINE) && (!r_href || r_vs);
      w_line_err  = w_close && ((r_x != C_H_PIX) || (C_RGB && r_phase) || r_vs);
      w_y_nxt     = w_close ? sat_inc(r_y) : r_y;
      w_frame_end = w_in_frame && r_vs && r_started && (w_y_nxt != '0);
      w_frame_err = w_frame_end && (r_err_acc || w_line_err || (w_y_nxt != C_V_LINES));
      w_pix_word  = C_RGB ? {r_hi, r_data} : {8'h00, r_data};
   end

   always_ff @(posedge PCLK_cam or posedge rst) begin
      if (rst) begin
         r_hi       <= '0;
         r_phase    <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_err_acc  <= 1'b0;
         r_started  <= 1'b0;
         r_s2_vld   <= 1'b0;
         r_s2_first <= 1'b0;
         r_s2_word  <= '0;
         r_s2_x     <= '0;
         r_s2_y     <= '0;
      end else begin
         if (w_frame_begin) begin
            r_x       <= '0;
            r_y       <= '0;
            r_err_acc <= 1'b0;
            r_started <= 1'b0;
            r_phase   <= 1'b0;
         end else begin
            if (w_cap && C_RGB) begin
               if (!w_phase) begin
                  r_hi    <= r_data;
                  r_phase <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
               end
            end
            if (w_pix) begin
               r_x       <= sat_inc(r_x);
               r_started <= 1'b1;
            end
            // A dangling high byte is dropped here simply by clearing the phase
            if (w_close) begin
               r_x       <= '0;
               r_y       <= w_y_nxt;
               r_phase   <= 1'b0;
               r_err_acc <= r_err_acc | w_line_err;
            end
         end
         r_s2_vld   <= w_pix;
         r_s2_first <= w_pix && !r_started;
         r_s2_word  <= w_pix_word;
         r_s2_x     <= r_x;
         r_s2_y     <= r_y;
      end
   end

   always_ff @(posedge PCLK_cam or posedge rst) begin
      if (rst) begin
         r_pix_data    <= '0;
         r_pix_valid   <= 1'b0;
         r_pix_x       <= '0;
         r_line_y      <= '0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_pix_valid   <= r_s2_vld;
         r_frame_start <= r_s2_vld && r_s2_first;
         r_frame_end   <= w_frame_end;
         r_frame_err   <= w_frame_err;
         if (r_s2_vld) begin
            r_pix_data <= r_s2_word;
            r_pix_x    <= r_s2_x;
            r_line_y   <= r_s2_y;
         end
      end
   end

   assign bus.pix_data    = r_pix_data;
   assign bus.pix_valid   = r_pix_valid;
   assign bus.pix_x       = r_pix_x;
   assign bus.line_y      = r_line_y;
   assign bus.frame_start = r_frame_start;
   assign bus.frame_end   = r_frame_end;
   assign bus.frame_err   = r_frame_err;

`ifdef DVP_CAPTURE_STATS_EN
   logic [W_CNT-1:0] r_frame_cnt;
   logic [W_CNT-1:0] r_err_cnt;

   // Counters follow the registered pulses, so they update the cycle after each pulse
   always_ff @(posedge PCLK_cam or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (r_frame_end) r_frame_cnt <= r_frame_cnt + W_CNT'(1);
         if (r_frame_err) r_err_cnt   <= r_err_cnt + W_CNT'(1);
      end
   end

   assign bus.frame_cnt = r_frame_cnt;
   assign bus.err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture: an RGB565 and a grayscale instance share one camera stream.
module tb_dvp_capture;

   typedef struct {
      int          pix;
      int          fs;
      int          fe;
      int          ferr;
      int          fs_bad;
      logic [15:0] d;
      logic [15:0] x;
      logic [15:0] y;
   } mon_t;

   typedef struct {
      int          nl;
      int          nb;
      logic [7:0]  base;
      bit          incr;
      int          p2;
      int          e2;
      logic [15:0] d2;
      logic [15:0] x2;
      logic [15:0] y2;
      int          p1;
      int          e1;
      logic [15:0] d1;
      logic [15:0] x1;
      logic [15:0] y1;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tb_data = 8'h00;
   logic       tb_vs = 1'b0;
   logic       tb_href = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_fc  = 0;
   int exp_ec  = 0;

   mon_t m2 = '{0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0};
   mon_t m1 = '{0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0};
   mon_t s2;
   mon_t s1;

   always #5 clk = ~clk;

   dvp_capture_if u_if2 ();
   dvp_capture_if u_if1 ();

   assign u_if2.data_cam  = tb_data;
   assign u_if2.VSYNC_cam = tb_vs;
   assign u_if2.HREF_cam  = tb_href;
   assign u_if1.data_cam  = tb_data;
   assign u_if1.VSYNC_cam = tb_vs;
   assign u_if1.HREF_cam  = tb_href;

   dvp_capture #(.COLOR_MODE(2), .H_PIX(4), .V_LINES(2)) u_dut2 (
      .PCLK_cam (clk),
      .rst      (rst),
      .bus      (u_if2.slave)
   );

   dvp_capture #(.COLOR_MODE(1), .H_PIX(4), .V_LINES(2)) u_dut1 (
      .PCLK_cam (clk),
      .rst      (rst),
      .bus      (u_if1.slave)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (u_if2.pix_valid) begin
            m2.pix = m2.pix + 1;
            m2.d   = u_if2.pix_data;
            m2.x   = u_if2.pix_x;
            m2.y   = u_if2.line_y;
         end
         if (u_if2.frame_start) begin
            m2.fs = m2.fs + 1;
            if (!u_if2.pix_valid || u_if2.pix_x != 16'h0 || u_if2.line_y != 16'h0)
               m2.fs_bad = m2.fs_bad + 1;
         end
         if (u_if2.frame_end) m2.fe = m2.fe + 1;
         if (u_if2.frame_err) begin
            m2.ferr = m2.ferr + 1;
            if (!u_if2.frame_end) m2.fs_bad = m2.fs_bad + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (u_if1.pix_valid) begin
            m1.pix = m1.pix + 1;
            m1.d   = u_if1.pix_data;
            m1.x   = u_if1.pix_x;
            m1.y   = u_if1.line_y;
         end
         if (u_if1.frame_start) begin
            m1.fs = m1.fs + 1;
            if (!u_if1.pix_valid || u_if1.pix_x != 16'h0 || u_if1.line_y != 16'h0)
               m1.fs_bad = m1.fs_bad + 1;
         end
         if (u_if1.frame_end) m1.fe = m1.fe + 1;
         if (u_if1.frame_err) begin
            m1.ferr = m1.ferr + 1;
            if (!u_if1.frame_end) m1.fs_bad = m1.fs_bad + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
      tb_vs   = vs;
      tb_href = hr;
      tb_data = d;
      @(negedge clk);
   endtask

   task automatic do_line(input int nb, input logic [7:0] base, input bit incr);
      for (int i = 0; i < nb; i++) cyc(1'b0, 1'b1, incr ? base + 8'(i) : base);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vs_pulse();
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic chk_frame(input string tag, input mon_t a, input mon_t s, input int pix,
                            input int ferr, input logic [15:0] d, input logic [15:0] x,
                            input logic [15:0] y);
      chk({tag, "_pix"},  32'(a.pix - s.pix),   32'(pix));
      chk({tag, "_fs"},   32'(a.fs - s.fs),     32'd1);
      chk({tag, "_fe"},   32'(a.fe - s.fe),     32'd1);
      chk({tag, "_ferr"}, 32'(a.ferr - s.ferr), 32'(ferr));
      chk({tag, "_data"}, 32'(a.d), 32'(d));
      chk({tag, "_x"},    32'(a.x), 32'(x));
      chk({tag, "_y"},    32'(a.y), 32'(y));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      tbl[0] = '{2, 8, 8'h10, 1'b1,  8, 0, 16'h1617, 16'd3, 16'd1, 16, 1, 16'h0017, 16'd7, 16'd1};
      tbl[1] = '{2, 4, 8'h55, 1'b1,  4, 1, 16'h5758, 16'd1, 16'd1,  8, 0, 16'h0058, 16'd3, 16'd1};
      tbl[2] = '{2, 7, 8'hA0, 1'b1,  6, 1, 16'hA4A5, 16'd2, 16'd1, 14, 1, 16'h00A6, 16'd6, 16'd1};
      tbl[3] = '{3, 8, 8'h20, 1'b1, 12, 1, 16'h2627, 16'd3, 16'd2, 24, 1, 16'h0027, 16'd7, 16'd2};
      tbl[4] = '{1, 8, 8'h30, 1'b1,  4, 1, 16'h3637, 16'd3, 16'd0,  8, 1, 16'h0037, 16'd7, 16'd0};
      tbl[5] = '{2, 8, 8'hAA, 1'b1,  8, 0, 16'hB0B1, 16'd3, 16'd1, 16, 1, 16'h00B1, 16'd7, 16'd1};
      tbl[6] = '{2, 4, 8'h55, 1'b0,  4, 1, 16'h5555, 16'd1, 16'd1,  8, 0, 16'h0055, 16'd3, 16'd1};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pix_data",    32'(u_if2.pix_data),    32'h0);
      chk("rst_pix_valid",   32'(u_if2.pix_valid),   32'h0);
      chk("rst_pix_x",       32'(u_if2.pix_x),       32'h0);
      chk("rst_line_y",      32'(u_if2.line_y),      32'h0);
      chk("rst_frame_start", 32'(u_if2.frame_start), 32'h0);
      chk("rst_frame_end",   32'(u_if2.frame_end),   32'h0);
      chk("rst_frame_err",   32'(u_if2.frame_err),   32'h0);
      chk("rst_m1_valid",    32'(u_if1.pix_valid),   32'h0);
      rst = 1'b0;
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      vs_pulse();

      // Table of whole frames
      for (int v = 0; v < 7; v++) begin
         s2 = m2;
         s1 = m1;
         for (int l = 0; l < tbl[v].nl; l++) do_line(tbl[v].nb, tbl[v].base, tbl[v].incr);
         vs_pulse();
         chk_frame($sformatf("vec%0d_m2", v), m2, s2, tbl[v].p2, tbl[v].e2,
                   tbl[v].d2, tbl[v].x2, tbl[v].y2);
         chk_frame($sformatf("vec%0d_m1", v), m1, s1, tbl[v].p1, tbl[v].e1,
                   tbl[v].d1, tbl[v].x1, tbl[v].y1);
         exp_fc = exp_fc + 1;
         exp_ec = exp_ec + tbl[v].e2;
      end

      // Two-cycle latency on a single AA,BB pair at the start of a frame
      s2 = m2;
      cyc(1'b0, 1'b1, 8'hAA);
      cyc(1'b0, 1'b1, 8'hBB);
      cyc(1'b0, 1'b0, 8'h00);
      chk("lat_not_yet", 32'(u_if2.pix_valid), 32'h0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("lat_valid",   32'(u_if2.pix_valid),   32'h1);
      chk("lat_data",    32'(u_if2.pix_data),    32'hAABB);
      chk("lat_x",       32'(u_if2.pix_x),       32'h0);
      chk("lat_y",       32'(u_if2.line_y),      32'h0);
      chk("lat_fstart",  32'(u_if2.frame_start), 32'h1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("lat_one_shot", 32'(u_if2.pix_valid), 32'h0);
      vs_pulse();
      chk("lat_fe",   32'(m2.fe - s2.fe),     32'd1);
      chk("lat_ferr", 32'(m2.ferr - s2.ferr), 32'd1);
      exp_fc = exp_fc + 1;
      exp_ec = exp_ec + 1;

      // VSYNC rising inside a complete second line closes it as an error
      s2 = m2;
      do_line(8, 8'h40, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h50 + 8'(i));
      cyc(1'b1, 1'b1, 8'h58);
      cyc(1'b1, 1'b1, 8'h59);
      repeat (2) cyc(1'b1, 1'b0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      chk_frame("vsline_m2", m2, s2, 8, 1, 16'h5657, 16'd3, 16'd1);
      exp_fc = exp_fc + 1;
      exp_ec = exp_ec + 1;

      // HREF during VSYNC is ignored and does not advance the line count
      do_line(8, 8'h80, 1'b1);
      do_line(8, 8'h88, 1'b1);
      s2 = m2;
      repeat (2) cyc(1'b1, 1'b0, 8'h00);
      repeat (4) cyc(1'b1, 1'b1, 8'h99);
      repeat (2) cyc(1'b1, 1'b0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      chk("vshref_pix",  32'(m2.pix - s2.pix),   32'd0);
      chk("vshref_fe",   32'(m2.fe - s2.fe),     32'd1);
      chk("vshref_ferr", 32'(m2.ferr - s2.ferr), 32'd0);
      s2 = m2;
      do_line(8, 8'hC0, 1'b1);
      do_line(8, 8'hC8, 1'b1);
      vs_pulse();
      chk_frame("vshref_next", m2, s2, 8, 0, 16'hCECF, 16'd3, 16'd1);
      exp_fc = exp_fc + 2;

`ifdef DVP_CAPTURE_STATS_EN
      chk("stats_frame_cnt", 32'(u_if2.frame_cnt), 32'(exp_fc));
      chk("stats_err_cnt",   32'(u_if2.err_cnt),   32'(exp_ec));
`endif

      // Reset mid-line: outputs clear at once, nothing until a fresh VSYNC high-then-low
      s2 = m2;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h61 + 8'(i));
      chk("prerst_valid", 32'(u_if2.pix_valid), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_pix_data",  32'(u_if2.pix_data),    32'h0);
      chk("midrst_pix_valid", 32'(u_if2.pix_valid),   32'h0);
      chk("midrst_fstart",    32'(u_if2.frame_start), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h65 + 8'(i));
      repeat (3) cyc(1'b0, 1'b0, 8'h00);
      do_line(8, 8'h69, 1'b1);
      chk("postrst_pix", 32'(m2.pix - s2.pix), 32'd1);
      chk("postrst_fs",  32'(m2.fs - s2.fs),   32'd1);
      vs_pulse();
      chk("postrst_fe",  32'(m2.fe - s2.fe),   32'd0);
      s2 = m2;
      do_line(8, 8'h70, 1'b1);
      do_line(8, 8'h70, 1'b1);
      vs_pulse();
      chk_frame("postrst_frame", m2, s2, 8, 0, 16'h7677, 16'd3, 16'd1);

`ifdef DVP_CAPTURE_STATS_EN
      chk("stats_post_frame_cnt", 32'(u_if2.frame_cnt), 32'd1);
      chk("stats_post_err_cnt",   32'(u_if2.err_cnt),   32'd0);
`endif

      chk("m2_pulse_alignment", 32'(m2.fs_bad), 32'd0);
      chk("m1_pulse_alignment", 32'(m1.fs_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dvp_capture.md
DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 Parameter COLOR_MODE, default 2, meaning: 2 = RGB565 two bytes per pixel, 1 = 8-bit grayscale one byte per pixel.
REQ-002 Parameter H_PIX, default 640, meaning: expected pixels per line.
REQ-003 Parameter V_LINES, default 480, meaning: expected lines per frame.
REQ-004 PCLK_cam  input  1  the only clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_cam  input  8  camera data byte.
REQ-007 VSYNC_cam  input  1  frame sync; high marks the inter-frame interval.
REQ-008 HREF_cam  input  1  line valid; high while data_cam carries pixel bytes.
REQ-009 pix_data  output  16  captured pixel: RGB565 {R,G,B}, or {8'h00, Y} in mode 1.
REQ-010 pix_valid  output  1  one-cycle strobe qualifying pix_data, pix_x and line_y.
REQ-011 pix_x, line_y  output  16 each  coordinates of the current pixel, starting at 0.
REQ-012 frame_start, frame_end, frame_err  output  1 each  one-cycle status pulses.

Function
REQ-013 data_cam, VSYNC_cam and HREF_cam SHALL be registered once (input stage) before any use.
REQ-014 FSM states SHALL be WAIT_VS, VS_HIGH, ACTIVE and LINE.
- WAIT_VS -> VS_HIGH on registered VSYNC high.
- VS_HIGH -> ACTIVE on VSYNC low.
- ACTIVE -> LINE on HREF high.
- LINE -> ACTIVE on HREF low.
- ACTIVE or LINE -> VS_HIGH on VSYNC high.
REQ-015 No pixel SHALL be output in WAIT_VS, so a partial frame after reset is discarded.
REQ-016 Mode 2: the first byte of each pair SHALL be the high byte and the second the low byte; pix_data = {first, second}.
REQ-017 Byte-pair phase SHALL reset to "first" at every HREF rising edge.
REQ-018 Mode 1: every HREF-qualified byte SHALL produce one pixel.
REQ-019 Latency: pix_valid SHALL assert exactly 2 PCLK_cam cycles after the edge that samples the completing byte.
REQ-020 pix_x SHALL reset to 0 at each line start and increment after each pix_valid.
REQ-021 line_y SHALL reset to 0 at frame start and increment at each HREF falling edge in LINE.
REQ-022 pix_x and line_y SHALL saturate at 16'hFFFF.
REQ-023 frame_start SHALL pulse coincident with the first pix_valid of a frame.
REQ-024 frame_end SHALL pulse one cycle after the registered VSYNC rising edge, but only if at least one line was captured since the last frame_start.
REQ-025 frame_err SHALL pulse together with frame_end if any of these occurred in the frame:
- a line whose pixel count is not H_PIX;
- a line count not equal to V_LINES;
- mode 2 only: an odd byte count in a line.
REQ-026 Mode 2: a dangling first byte at HREF fall SHALL be discarded with no pix_valid.
REQ-027 HREF high while VSYNC is high SHALL be ignored: no pixels, and line_y is not advanced.
REQ-028 If VSYNC rises while in LINE, the line SHALL be closed, counted and flagged as an error.

Reset
REQ-029 On rst high, all outputs SHALL be 0, the FSM SHALL enter WAIT_VS, and all counters, error flags and input registers SHALL clear, asynchronously.
REQ-030 A reset asserted mid-frame SHALL suppress all pulses until a complete VS_HIGH -> ACTIVE sequence is seen.

Configuration
REQ-031 Macro DVP_CAPTURE_STATS_EN, when defined, SHALL add two 16-bit outputs:
- frame_cnt: increments on each frame_end;
- err_cnt: increments on each frame_err;
- both wrap at 16'hFFFF, reset to 0, and update on the cycle after the pulse.
REQ-032 When the macro is undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Mode 2, H_PIX=4, V_LINES=2, one line of bytes AA,BB -> pix_data=16'hAABB on pix_valid, with exactly 2 cycles of latency.
REQ-034 Two 4x2 frames in mode 2 -> 8 pix_valid per frame; frame_start on (0,0); frame_end after VSYNC rises; frame_err=0.
REQ-035 Mode 1, byte 8'h55 -> pix_data=16'h0055 on every HREF cycle; pix_x increments 0..H_PIX-1.
REQ-036 Mode 2, 7-byte line -> 3 pixels; 7th byte dropped; frame_err=1 with frame_end.
REQ-037 rst pulsed mid-line of frame 1 -> outputs 0 immediately; no pix_valid until after the next VSYNC high-then-low; frame 2 captured cleanly.
REQ-038 With DVP_CAPTURE_STATS_EN, 3 frames with 1 malformed -> frame_cnt=3, err_cnt=1.
